// File: rtl/flag_pkg.sv
// Shared types and constants for the NZCV condition-flag path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: flag_op_e (ALU flag operation class), nzcv_t ({n,z,c,v}), bit
// indices into a 4-bit NZCV vector, and the reset value of the flags.
package flag_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_LOGIC = 2'd2,
        OP_NONE  = 2'd3
    } flag_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam nzcv_t NZCV_RESET = nzcv_t'(4'b0000);

endpackage

// File: rtl/flag_gen.sv
// Combinational NZCV generator from one ALU result and its operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs every cycle.
// Ports: op, a, b, result, cout (ALU result and operands, b un-inverted),
//        c_prev/v_prev (committed C and V, kept for logic ops), flags (NZCV out).
module flag_gen
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  flag_op_e           op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   result,
    input  logic               cout,
    input  logic               c_prev,
    input  logic               v_prev,
    output nzcv_t              flags
);

    logic a_msb;
    logic b_msb;
    logic r_msb;

    assign a_msb = a[WIDTH-1];
    assign b_msb = b[WIDTH-1];
    assign r_msb = result[WIDTH-1];

    // Overflow only depends on sign bits; the low operand bits are carried
    // through the interface so other pipelines can reuse this block as-is.
    logic unused_low_bits;
    assign unused_low_bits = ^{a[WIDTH-2:0], b[WIDTH-2:0]};

    always_comb begin
        flags   = nzcv_t'(4'b0000);
        flags.n = r_msb;
        flags.z = (result == '0);
        flags.c = c_prev;
        flags.v = v_prev;
        case (op)
            OP_ADD: begin
                flags.c = cout;
                flags.v = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB: begin
                // b is the un-inverted operand, so operands of differing sign
                // are the ones that can overflow a subtraction.
                flags.c = cout;
                flags.v = (a_msb != b_msb) && (r_msb != a_msb);
            end
            default: begin
                flags.c = c_prev;
                flags.v = v_prev;
            end
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// NZCV status register fed by ALU results through a one-entry pending stage.
// Latency: capture at T, flags_byp shows the new value at T+1, flags_out at T+2.
// Backpressure: none; one update per cycle sustained, flush kills the pending entry.
// Ports: ALU side (alu_valid, alu_op, alu_a, alu_b, alu_result, alu_cout,
//        set_flags, cond_ex), control (flush, wr_en/wr_flags, save_req,
//        restore_req), outputs flags_out (committed), flags_byp (pending-
//        inclusive), pend_valid, saved_flags.
// Optional save/restore of the flags is built only when FLAG_SAVE_EN is
// defined; otherwise save_req/restore_req are ignored and saved_flags is 0000.
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_valid,
    input  logic [1:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_a,
    input  logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_cout,
    input  logic               set_flags,
    input  logic               cond_ex,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [3:0]         wr_flags,
    input  logic               save_req,
    input  logic               restore_req,
    output logic [3:0]         flags_out,
    output logic [3:0]         flags_byp,
    output logic               pend_valid,
    output logic [3:0]         saved_flags
);

    flag_op_e          cap_op;
    logic              capture;
    logic              commit;
    logic              restore_act;

    logic              pend_valid_q;
    flag_op_e          pend_op_q;
    logic [WIDTH-1:0]  pend_a_q;
    logic [WIDTH-1:0]  pend_b_q;
    logic [WIDTH-1:0]  pend_r_q;
    logic              pend_cout_q;

    nzcv_t             flags_q;
    nzcv_t             flags_d;
    nzcv_t             gen_flags;
    nzcv_t             byp_flags;
    nzcv_t             saved_q;

    assign cap_op  = flag_op_e'(alu_op);
    assign capture = alu_valid && set_flags && cond_ex && (cap_op != OP_NONE) && !flush;
    assign commit  = pend_valid_q && !flush;

    // Pending stage: a new capture may refill it in the same cycle the older
    // entry commits, which keeps one flag update per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_op_q    <= OP_ADD;
            pend_a_q     <= '0;
            pend_b_q     <= '0;
            pend_r_q     <= '0;
            pend_cout_q  <= 1'b0;
        end else begin
            pend_valid_q <= capture && !restore_act;
            if (capture) begin
                pend_op_q   <= cap_op;
                pend_a_q    <= alu_a;
                pend_b_q    <= alu_b;
                pend_r_q    <= alu_result;
                pend_cout_q <= alu_cout;
            end
        end
    end

    // C/V for logic ops come from the committed register; any older update
    // has already committed by the time this entry is pending.
    flag_gen #(
        .WIDTH  (WIDTH)
    ) u_flag_gen (
        .op     (pend_op_q),
        .a      (pend_a_q),
        .b      (pend_b_q),
        .result (pend_r_q),
        .cout   (pend_cout_q),
        .c_prev (flags_q.c),
        .v_prev (flags_q.v),
        .flags  (gen_flags)
    );

    // Restore beats an explicit write, which beats the pending commit.
    always_comb begin
        flags_d = flags_q;
        if (restore_act) begin
            flags_d = saved_q;
        end else if (wr_en) begin
            flags_d = nzcv_t'(wr_flags);
        end else if (commit) begin
            flags_d = gen_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= NZCV_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign byp_flags = pend_valid_q ? gen_flags : flags_q;

`ifdef FLAG_SAVE_EN
    assign restore_act = restore_req;

    // On a simultaneous save and restore the restore reads the old value
    // (flags_d above) while the save still lands here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_q <= NZCV_RESET;
        end else if (save_req) begin
            saved_q <= byp_flags;
        end
    end
`else
    logic unused_save_ports;
    assign unused_save_ports = save_req ^ restore_req;
    assign restore_act       = 1'b0;
    assign saved_q           = NZCV_RESET;
`endif

    assign flags_out   = flags_q;
    assign flags_byp   = byp_flags;
    assign pend_valid  = pend_valid_q;
    assign saved_flags = saved_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           alu_valid;
    logic [1:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_result;
    logic           alu_cout;
    logic           set_flags;
    logic           cond_ex;
    logic           flush;
    logic           wr_en;
    logic [3:0]     wr_flags;
    logic           save_req;
    logic           restore_req;
    logic [3:0]     flags_out;
    logic [3:0]     flags_byp;
    logic           pend_valid;
    logic [3:0]     saved_flags;

    flag_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .set_flags   (set_flags),
        .cond_ex     (cond_ex),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_flags    (wr_flags),
        .save_req    (save_req),
        .restore_req (restore_req),
        .flags_out   (flags_out),
        .flags_byp   (flags_byp),
        .pend_valid  (pend_valid),
        .saved_flags (saved_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    localparam int SEL_OUT = 0;
    localparam int SEL_BYP = 1;
    localparam int SEL_PV  = 2;
    localparam int SEL_SAV = 3;

    typedef struct {
        string      name;
        int         cyc;
        int         sel;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic         vld;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         cout;
        logic         sf;
        logic         ce;
        logic         fl;
        logic [3:0]   pre;
        logic [3:0]   exp_byp;
        logic         exp_pv;
        logic [3:0]   exp_out;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [1:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] r, input logic cout,
                                input logic sf, input logic ce, input logic fl,
                                input logic [3:0] pre, input logic [3:0] eb,
                                input logic epv, input logic [3:0] eo);
        vec_t v;
        v.vld = vld; v.op = op; v.a = a; v.b = b; v.r = r; v.cout = cout;
        v.sf = sf; v.ce = ce; v.fl = fl; v.pre = pre;
        v.exp_byp = eb; v.exp_pv = epv; v.exp_out = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // Keep the scoreboard ordered by due cycle.
    function automatic void expect_at(input string name, input int at, input int sel,
                                      input logic [3:0] v);
        exp_t e;
        int   i;
        e.name = name; e.cyc = at; e.sel = sel; e.exp = v;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= at) i++;
        sb.insert(i, e);
    endfunction

    function automatic logic [3:0] observe(input int sel);
        case (sel)
            SEL_OUT: return flags_out;
            SEL_BYP: return flags_byp;
            SEL_PV:  return {3'b000, pend_valid};
            default: return saved_flags;
        endcase
    endfunction

    always @(negedge clk) begin : sb_check
        exp_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    n_total++;
                    $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
                end else begin
                    check(e.name, observe(e.sel), e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_op = 2'd3; alu_a = '0; alu_b = '0; alu_result = '0;
        alu_cout = 1'b0; set_flags = 1'b0; cond_ex = 1'b0; flush = 1'b0;
        wr_en = 1'b0; wr_flags = 4'b0000; save_req = 1'b0; restore_req = 1'b0;
    endtask

    task automatic alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic co);
        alu_valid = 1'b1; set_flags = 1'b1; cond_ex = 1'b1;
        alu_op = op; alu_a = a; alu_b = b; alu_result = r; alu_cout = co;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vt[13];
        int   c;
        exp_t e;

        //             vld op    a             b             r             co sf ce fl pre      byp     pv out
        vt[0]  = mk(1, 2'd1, 32'd5,        32'd5,        32'd0,        1, 1, 1, 0, 4'b0000, 4'b0110, 1, 4'b0110);
        vt[1]  = mk(1, 2'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 1, 1, 0, 4'b0000, 4'b1001, 1, 4'b1001);
        vt[2]  = mk(1, 2'd2, 32'd0,        32'd0,        32'd0,        0, 1, 1, 0, 4'b1001, 4'b0101, 1, 4'b0101);
        vt[3]  = mk(1, 2'd1, 32'd5,        32'd5,        32'd0,        1, 1, 0, 0, 4'b1000, 4'b1000, 0, 4'b1000);
        vt[4]  = mk(1, 2'd1, 32'd5,        32'd5,        32'd0,        1, 0, 1, 0, 4'b0011, 4'b0011, 0, 4'b0011);
        vt[5]  = mk(1, 2'd3, 32'd5,        32'd5,        32'd0,        1, 1, 1, 0, 4'b0001, 4'b0001, 0, 4'b0001);
        vt[6]  = mk(0, 2'd1, 32'd5,        32'd5,        32'd0,        1, 1, 1, 0, 4'b1100, 4'b1100, 0, 4'b1100);
        vt[7]  = mk(1, 2'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 1, 1, 0, 4'b0111, 4'b1000, 1, 4'b1000);
        vt[8]  = mk(1, 2'd1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1, 1, 1, 0, 4'b0000, 4'b0011, 1, 4'b0011);
        vt[9]  = mk(1, 2'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 1, 1, 0, 4'b1001, 4'b0110, 1, 4'b0110);
        vt[10] = mk(1, 2'd0, 32'h80000000, 32'h80000000, 32'd0,        1, 1, 1, 0, 4'b0000, 4'b0111, 1, 4'b0111);
        vt[11] = mk(1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 1, 1, 0, 4'b0110, 4'b1010, 1, 4'b1010);
        vt[12] = mk(1, 2'd1, 32'd5,        32'd5,        32'd0,        1, 1, 1, 1, 4'b1111, 4'b1111, 0, 4'b1111);

        // Reset with busy inputs: outputs must be zero immediately and across an edge.
        rst_n = 1'b0;
        alu(2'd1, 32'd5, 32'd5, 32'd0, 1'b1);
        wr_en = 1'b1; wr_flags = 4'b1111; save_req = 1'b1; restore_req = 1'b1; flush = 1'b0;
        #3;
        check("reset_out", flags_out, 4'b0000);
        check("reset_byp", flags_byp, 4'b0000);
        check("reset_pv", {3'b000, pend_valid}, 4'b0000);
        check("reset_saved", saved_flags, 4'b0000);
        #5;
        check("reset_out_after_edge", flags_out, 4'b0000);
        idle();
        #4 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(); idle();
            wr_en = 1'b1; wr_flags = vt[i].pre;
            step(); idle();
            alu_valid = vt[i].vld; alu_op = vt[i].op; alu_a = vt[i].a; alu_b = vt[i].b;
            alu_result = vt[i].r; alu_cout = vt[i].cout; set_flags = vt[i].sf;
            cond_ex = vt[i].ce; flush = vt[i].fl;
            c = cyc;
            expect_at($sformatf("v%0d_byp", i), c + 1, SEL_BYP, vt[i].exp_byp);
            expect_at($sformatf("v%0d_pv", i),  c + 1, SEL_PV,  {3'b000, vt[i].exp_pv});
            expect_at($sformatf("v%0d_out", i), c + 2, SEL_OUT, vt[i].exp_out);
            step(); idle();
            step();
        end

        // Back-to-back: ADD overflow then LOGIC r=0 keeping C=0, V=1.
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b0000;
        step(); idle(); alu(2'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0); c = cyc;
        expect_at("b2b_byp1", c + 1, SEL_BYP, 4'b1001);
        step(); idle(); alu(2'd2, 32'd0, 32'd0, 32'd0, 1'b0);
        expect_at("b2b_out1", c + 2, SEL_OUT, 4'b1001);
        expect_at("b2b_byp2", c + 2, SEL_BYP, 4'b0101);
        expect_at("b2b_pv2",  c + 2, SEL_PV,  4'b0001);
        expect_at("b2b_out2", c + 3, SEL_OUT, 4'b0101);
        expect_at("b2b_pv3",  c + 3, SEL_PV,  4'b0000);
        step(); idle(); step();

        // Flush in the commit cycle discards the pending update.
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b1000;
        step(); idle(); alu(2'd1, 32'd5, 32'd5, 32'd0, 1'b1); c = cyc;
        expect_at("flush_byp_pending", c + 1, SEL_BYP, 4'b0110);
        step(); idle(); flush = 1'b1;
        expect_at("flush_out", c + 2, SEL_OUT, 4'b1000);
        expect_at("flush_pv",  c + 2, SEL_PV,  4'b0000);
        expect_at("flush_byp", c + 2, SEL_BYP, 4'b1000);
        step(); idle(); step();

        // Explicit write in the commit cycle wins over the commit.
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b0000;
        step(); idle(); alu(2'd1, 32'd5, 32'd5, 32'd0, 1'b1); c = cyc;
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b1010;
        expect_at("wr_commit_out", c + 2, SEL_OUT, 4'b1010);
        expect_at("wr_commit_pv",  c + 2, SEL_PV,  4'b0000);
        step(); idle(); step();

        // Explicit write and capture in the same cycle: both take effect.
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b1100;
        alu(2'd1, 32'd5, 32'd5, 32'd0, 1'b1); c = cyc;
        expect_at("wr_cap_out1", c + 1, SEL_OUT, 4'b1100);
        expect_at("wr_cap_byp1", c + 1, SEL_BYP, 4'b0110);
        expect_at("wr_cap_out2", c + 2, SEL_OUT, 4'b0110);
        step(); idle(); step();

`ifdef FLAG_SAVE_EN
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b0110; c = cyc;
        step(); idle(); save_req = 1'b1;
        expect_at("save_saved", c + 2, SEL_SAV, 4'b0110);
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b0000;
        expect_at("save_cleared", c + 3, SEL_OUT, 4'b0000);
        step(); idle(); restore_req = 1'b1;
        expect_at("restore_out", c + 4, SEL_OUT, 4'b0110);
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b1001;
        step(); idle(); save_req = 1'b1; restore_req = 1'b1;
        expect_at("save_restore_out",   c + 6, SEL_OUT, 4'b0110);
        expect_at("save_restore_saved", c + 6, SEL_SAV, 4'b1001);
        step(); idle(); step();
`else
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b0011; c = cyc;
        step(); idle(); save_req = 1'b1;
        step(); idle(); restore_req = 1'b1;
        expect_at("nosave_saved1",  c + 2, SEL_SAV, 4'b0000);
        expect_at("nosave_restore", c + 3, SEL_OUT, 4'b0011);
        expect_at("nosave_saved2",  c + 3, SEL_SAV, 4'b0000);
        step(); idle(); step();
`endif

        // Reset while an update is pending: entry lost, flags back to zero.
        step(); idle(); wr_en = 1'b1; wr_flags = 4'b1111;
        step(); idle(); alu(2'd1, 32'd5, 32'd5, 32'd0, 1'b1);
        step(); idle();
        check("midrst_pv_before", {3'b000, pend_valid}, 4'b0001);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out", flags_out, 4'b0000);
        check("midrst_byp", flags_byp, 4'b0000);
        check("midrst_pv",  {3'b000, pend_valid}, 4'b0000);
        #1 rst_n = 1'b1;
        step();
        check("midrst_out_after", flags_out, 4'b0000);
        check("midrst_pv_after",  {3'b000, pend_valid}, 4'b0000);

        for (int k = 0; k < 10; k++) begin
            if (sb.size() > 0) step();
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            $display("FAIL %s: never checked (due cycle %0d)", e.name, e.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
